// File: rtl/tmds_pkg.sv
// Shared TMDS/HDMI definitions: mode encodings, fixed symbol codes, TERC4 table and popcount.
package tmds_pkg;

    localparam int unsigned SYM_W = 10;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VID_GB = 3'd2,
        MODE_ISL_GB = 3'd3,
        MODE_ISLAND = 3'd4
    } mode_e;

    // Per-symbol side-band carried down the pipeline next to the pixel data
    typedef struct packed {
        logic [2:0] mode;
        logic [1:0] ctrl;
        logic [3:0] aux;
    } sym_ctl_t;

    localparam logic [SYM_W-1:0] CTRL_CODE_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_CODE_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_CODE_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_CODE_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] GB_CODE_BR = 10'b1011001100;
    localparam logic [SYM_W-1:0] GB_CODE_G  = 10'b0100110011;

    function automatic logic [SYM_W-1:0] ctrl_code(input logic [1:0] c);
        logic [SYM_W-1:0] s;
        s = CTRL_CODE_00;
        case (c)
            2'b00: s = CTRL_CODE_00;
            2'b01: s = CTRL_CODE_01;
            2'b10: s = CTRL_CODE_10;
            2'b11: s = CTRL_CODE_11;
        endcase
        return s;
    endfunction

    function automatic logic [SYM_W-1:0] terc4(input logic [3:0] a);
        logic [SYM_W-1:0] s;
        s = '0;
        case (a)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            4'hF: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(d[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_dc_balance.sv
// DC-balancing stage: turns q_m into a 10b symbol and tracks the 5b running disparity.
module tmds_dc_balance
    import tmds_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [8:0]       q_m_i,
    input  logic [3:0]       n1_i,
    input  logic [3:0]       n0_i,
    input  logic             video_valid_i,
    output logic [SYM_W-1:0] sym_c,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d, diff;
    logic             cnt_pos, cnt_neg, q8;

    // Symbol and disparity update; two's complement wraps naturally in 5 bits
    always_comb begin
        q8      = q_m_i[8];
        diff    = CNT_W'(n1_i) - CNT_W'(n0_i);
        cnt_neg = cnt_q[CNT_W-1];
        cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);
        sym_c   = {1'b0, q8, q_m_i[7:0]};
        cnt_d   = cnt_q;
        if ((cnt_q == '0) || (n1_i == n0_i)) begin
            sym_c = {~q8, q8, q8 ? q_m_i[7:0] : ~q_m_i[7:0]};
            cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((cnt_pos && (n1_i > n0_i)) || (cnt_neg && (n0_i > n1_i))) begin
            sym_c = {1'b1, q8, ~q_m_i[7:0]};
            cnt_d = cnt_q + {3'b000, q8, 1'b0} - diff;
        end else begin
            sym_c = {1'b0, q8, q_m_i[7:0]};
            cnt_d = cnt_q - {3'b000, ~q8, 1'b0} + diff;
        end
        if (!video_valid_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// HDMI TMDS lane encoder: video, control, guard-band and TERC4 symbols through a fixed 3-stage pipeline.
module tmds_encoder_hdmi
    import tmds_pkg::*;
#(
    parameter int unsigned CHANNEL = 0
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [2:0]       mode,
    input  logic [7:0]       vid_data,
    input  logic [1:0]       ctrl,
    input  logic [3:0]       aux_data,
    output logic [SYM_W-1:0] data_out,
    output logic [CNT_W-1:0] disparity
);

    if (CHANNEL > 2) begin : g_bad_channel
        $error("tmds_encoder_hdmi: CHANNEL must be 0, 1 or 2");
    end

    sym_ctl_t         ctl_s1_q, ctl_s2_q;
    logic [7:0]       d_s1_q;
    logic [3:0]       n1d_s1_q;
    logic [8:0]       qm_d, qm_s2_q;
    logic [3:0]       qm_n1_d, n1_s2_q, n0_s2_q;
    logic             use_xnor;
    logic [SYM_W-1:0] data_d, data_q, vid_sym_c;

    // Transition minimisation on the S1 pixel
    always_comb begin
        use_xnor = (n1d_s1_q > 4'd4) || ((n1d_s1_q == 4'd4) && !d_s1_q[0]);
        qm_d     = '0;
        qm_d[0]  = d_s1_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d_s1_q[i]) : (qm_d[i-1] ^ d_s1_q[i]);
        end
        qm_d[8] = ~use_xnor;
        qm_n1_d = popcount8(qm_d[7:0]);
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ctl_s1_q <= '0;
            d_s1_q   <= '0;
            n1d_s1_q <= '0;
            ctl_s2_q <= '0;
            qm_s2_q  <= '0;
            n1_s2_q  <= '0;
            n0_s2_q  <= '0;
            data_q   <= '0;
        end else begin
            ctl_s1_q <= '{mode: mode, ctrl: ctrl, aux: aux_data};
            d_s1_q   <= vid_data;
            n1d_s1_q <= popcount8(vid_data);
            ctl_s2_q <= ctl_s1_q;
            qm_s2_q  <= qm_d;
            n1_s2_q  <= qm_n1_d;
            n0_s2_q  <= 4'd8 - qm_n1_d;
            data_q   <= data_d;
        end
    end

    tmds_dc_balance u_dc_balance (
        .clk_i         (vga_clk),
        .rst_i         (sys_rst),
        .q_m_i         (qm_s2_q),
        .n1_i          (n1_s2_q),
        .n0_i          (n0_s2_q),
        .video_valid_i (ctl_s2_q.mode == MODE_VIDEO),
        .sym_c         (vid_sym_c),
        .cnt_o         (disparity)
    );

    // S3 symbol select; unused mode encodings fall back to control codes
    always_comb begin
        data_d = ctrl_code(ctl_s2_q.ctrl);
        case (ctl_s2_q.mode)
            MODE_VIDEO:  data_d = vid_sym_c;
            MODE_VID_GB: data_d = (CHANNEL == 1) ? GB_CODE_G : GB_CODE_BR;
            MODE_ISL_GB: data_d = (CHANNEL == 0) ? terc4(ctl_s2_q.aux) : GB_CODE_G;
            MODE_ISLAND: data_d = terc4(ctl_s2_q.aux);
            default:     data_d = ctrl_code(ctl_s2_q.ctrl);
        endcase
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// Bench for tmds_encoder_hdmi: lanes 0 and 1 side by side against an integer reference model.
module tb_tmds_encoder_hdmi;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic [7:0] vid_data;
    logic [1:0] ctrl;
    logic [3:0] aux_data;
    logic [9:0] out0, out1;
    logic [4:0] disp0, disp1;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    typedef struct {
        logic [9:0] d0;
        logic [9:0] d1;
        logic [4:0] disp;
        string      tag;
    } exp_t;

    exp_t expq[$];

    logic [9:0] terc_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] gb_br = 10'b1011001100;
    logic [9:0] gb_g  = 10'b0100110011;

    always #5 clk = ~clk;

    tmds_encoder_hdmi #(.CHANNEL(0)) dut0 (
        .vga_clk(clk), .sys_rst(rst), .mode(mode), .vid_data(vid_data),
        .ctrl(ctrl), .aux_data(aux_data), .data_out(out0), .disparity(disp0));

    tmds_encoder_hdmi #(.CHANNEL(1)) dut1 (
        .vga_clk(clk), .sys_rst(rst), .mode(mode), .vid_data(vid_data),
        .ctrl(ctrl), .aux_data(aux_data), .data_out(out1), .disparity(disp1));

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] fixed_sym(input int ch, input logic [2:0] m,
                                             input logic [1:0] c, input logic [3:0] a);
        case (m)
            3'd2:    return (ch == 1) ? gb_g : gb_br;
            3'd3:    return (ch == 0) ? terc_tab[a] : gb_g;
            3'd4:    return terc_tab[a];
            default: return ctrl_tab[c];
        endcase
    endfunction

    // DVI video encoding computed with integer counts
    task automatic video_ref(input logic [7:0] d, output logic [9:0] sym);
        int         n1, q1, q0, b;
        bit         use_xnor;
        logic [8:0] qm;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        b  = qm[8] ? 1 : 0;
        q1 = $countones(qm[7:0]);
        q0 = 8 - q1;
        if (model_cnt == 0 || q1 == q0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            model_cnt += (b == 1) ? (q1 - q0) : (q0 - q1);
        end else if ((model_cnt > 0 && q1 > q0) || (model_cnt < 0 && q0 > q1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            model_cnt += 2 * b + q0 - q1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            model_cnt += -2 * (1 - b) + q1 - q0;
        end
    endtask

    // Drive one symbol, advance a cycle, then check the symbol issued three cycles earlier
    task automatic step(input logic [2:0] m, input logic [7:0] d, input logic [1:0] c,
                        input logic [3:0] a, input string tag);
        exp_t       e;
        logic [9:0] vs;
        int         sd;
        mode = m; vid_data = d; ctrl = c; aux_data = a;
        if (m == 3'd1) begin
            video_ref(d, vs);
            e.d0 = vs;
            e.d1 = vs;
        end else begin
            model_cnt = 0;
            e.d0 = fixed_sym(0, m, c, a);
            e.d1 = fixed_sym(1, m, c, a);
        end
        e.disp = 5'(model_cnt);
        e.tag  = tag;
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (expq.size() == 3) begin
            e = expq.pop_front();
            check({e.tag, "_lane0"}, out0, e.d0);
            check({e.tag, "_lane1"}, out1, e.d1);
            check({e.tag, "_disp0"}, 10'(disp0), 10'(e.disp));
            check({e.tag, "_disp1"}, 10'(disp1), 10'(e.disp));
            sd = int'($signed(disp0));
            check({e.tag, "_disp_bound"}, 10'(sd >= -10 && sd <= 10), 10'(1));
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        model_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; mode = 3'd0; vid_data = 8'h00; ctrl = 2'b00; aux_data = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out0", out0, 10'd0);
        check("reset_out1", out1, 10'd0);
        check("reset_disp", 10'(disp0), 10'd0);
        release_reset();

        for (int i = 0; i < 4; i++) step(3'd0, 8'h5A, 2'(i), 4'h0, "ctrl_cycle");

        for (int i = 0; i < 3; i++) step(3'd1, 8'h00, 2'b00, 4'h0, "video_zero");

        step(3'd0, 8'h00, 2'b10, 4'h0, "ctrl_after_video");

        for (int i = 0; i < 16; i++) step(3'd4, 8'hFF, 2'b00, 4'(i), "island");

        step(3'd3, 8'h00, 2'b00, 4'hC, "isl_gb");
        step(3'd0, 8'h00, 2'b01, 4'h0, "ctrl_seq");
        step(3'd2, 8'h00, 2'b00, 4'h0, "vid_gb");
        step(3'd2, 8'h00, 2'b00, 4'h0, "vid_gb");
        step(3'd1, 8'hA7, 2'b00, 4'h0, "video_seq");
        step(3'd0, 8'h00, 2'b11, 4'h0, "ctrl_seq");
        step(3'd6, 8'h00, 2'b10, 4'h0, "mode_undef");

        for (int i = 0; i < 40; i++) step(3'd1, 8'($urandom), 2'b00, 4'h0, "video_pre_reset");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_out0", out0, 10'd0);
        check("async_reset_out1", out1, 10'd0);
        check("async_reset_disp", 10'(disp0), 10'd0);
        release_reset();
        for (int i = 0; i < 6; i++) step(3'd1, 8'($urandom), 2'b00, 4'h0, "video_post_reset");

        for (int i = 0; i < 10000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 13) step(3'd1, 8'($urandom), 2'b00, 4'h0, "video_rand");
            else step(3'($urandom_range(0, 7)), 8'($urandom), 2'($urandom), 4'($urandom), "mixed_rand");
        end

        step(3'd0, 8'h00, 2'b00, 4'h0, "drain");
        step(3'd0, 8'h00, 2'b00, 4'h0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
